// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B.
// Grants a burst at a time and presents the selected beat with a valid/ready handshake.
module mux2_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_a,
    input  logic [WIDTH-1:0]                 a,
    input  logic                             last_a,
    input  logic                             req_b,
    input  logic [WIDTH-1:0]                 b,
    input  logic                             last_b,
    input  logic                             ready,
    output logic                             gnt_a,
    output logic                             gnt_b,
    output logic                             sel,
    output logic [WIDTH-1:0]                 y,
    output logic                             y_valid,
    output logic [$clog2(MAX_BURST+1)-1:0]   beat_cnt
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

    state_e            state_q, state_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              sel_q, sel_d;
    logic              ptr_q, ptr_d;     // 1: B won the last grant, so A wins the next tie
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic own_req, oth_req, own_last, xfer, hit_max, burst_end;
    logic go_a, go_b;

    always_comb begin
        own_req  = (state_q == StGntB) ? req_b  : req_a;
        oth_req  = (state_q == StGntB) ? req_a  : req_b;
        own_last = (state_q == StGntB) ? last_b : last_a;
        xfer      = own_req & ready;
        hit_max   = (cnt_q == CntW'(MAX_BURST - 1));
        burst_end = ~own_req | (xfer & (own_last | hit_max));
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        go_a    = 1'b0;
        go_b    = 1'b0;

        unique case (state_q)
            StIdle: begin
                go_a = req_a & (~req_b | ptr_q);
                go_b = req_b & ~go_a;
            end
            StGntA, StGntB: begin
                if (burst_end) begin
                    cnt_d = '0;
                    // The other side gets priority at burst end; otherwise re-grant or idle.
                    if (oth_req) begin
                        go_a = (state_q == StGntB);
                        go_b = (state_q == StGntA);
                    end else if (own_req) begin
                        go_a = (state_q == StGntA);
                        go_b = (state_q == StGntB);
                    end else begin
                        state_d = StIdle;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (go_a) begin
            state_d = StGntA;
            sel_d   = 1'b0;
            ptr_d   = 1'b0;
        end else if (go_b) begin
            state_d = StGntB;
            sel_d   = 1'b1;
            ptr_d   = 1'b1;
        end

        gnt_a_d = (state_d == StGntA);
        gnt_b_d = (state_d == StGntB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            sel_q   <= 1'b0;
            ptr_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        y       = '0;
        y_valid = 1'b0;
        if (gnt_a_q) begin
            y       = a;
            y_valid = req_a;
        end else if (gnt_b_q) begin
            y       = b;
            y_valid = req_b;
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign sel      = sel_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: directed scenarios then randomized traffic,
// checked against a burst-level reference model.
module tb_mux2_rr_arbiter;

    localparam int unsigned W    = 8;
    localparam int unsigned MAXB = 4;
    localparam int unsigned CW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a = 1'b0, last_a = 1'b0, req_b = 1'b0, last_b = 1'b0, ready = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          gnt_a, gnt_b, sel, y_valid;
    logic [W-1:0]  y;
    logic [CW-1:0] beat_cnt;

    mux2_rr_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .a(a), .last_a(last_a),
        .req_b(req_b), .b(b), .last_b(last_b),
        .ready(ready),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
        .y(y), .y_valid(y_valid), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ga; int gb; int sl; int vld; int cnt; int yv;
    } st_t;

    st_t st_q[$];
    int  xfer_q[$];    // {side, data} of every expected transfer
    int  n_cmp  = 0;
    int  n_fail = 0;

    // Reference model: owner 0=none 1=A 2=B
    int m_owner, m_cnt, m_last, m_sel;

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_last = 2; m_sel = 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic grant(input int who);
        m_owner = who;
        if (who != 0) begin
            m_last = who;
            m_sel  = (who == 2) ? 1 : 0;
        end
    endtask

    // Drive one cycle of inputs after the falling edge and predict its outcome.
    task automatic cycle(input bit r, input bit ra, input bit la, input bit rb, input bit lb,
                         input bit rdy, input logic [W-1:0] da, input logic [W-1:0] db);
        st_t e;
        int  own_r, oth_r, own_l, xf;
        @(negedge clk);
        rst_n = r; req_a = ra; last_a = la; req_b = rb; last_b = lb; ready = rdy;
        a = da; b = db;
        e.ga  = (m_owner == 1) ? 1 : 0;
        e.gb  = (m_owner == 2) ? 1 : 0;
        e.sl  = m_sel;
        e.cnt = m_cnt;
        e.vld = (m_owner == 1) ? int'(ra) : (m_owner == 2) ? int'(rb) : 0;
        e.yv  = (m_owner == 1) ? int'(da) : (m_owner == 2) ? int'(db) : 0;
        st_q.push_back(e);
        if (e.vld != 0 && rdy) xfer_q.push_back((m_owner << W) | e.yv);
        if (!r) return;
        if (m_owner == 0) begin
            if (ra && rb)  grant((m_last == 1) ? 2 : 1);
            else if (ra)   grant(1);
            else if (rb)   grant(2);
        end else begin
            own_r = (m_owner == 1) ? ra : rb;
            oth_r = (m_owner == 1) ? rb : ra;
            own_l = (m_owner == 1) ? la : lb;
            xf    = own_r && rdy;
            if (xf) m_cnt++;
            if (!own_r || (xf && (own_l || m_cnt == MAXB))) begin
                m_cnt = 0;
                if (oth_r)      grant(3 - m_owner);
                else if (own_r) grant(m_owner);
                else            grant(0);
            end
        end
    endtask

    // Monitor: per-cycle state check plus scoreboard pop on each handshake.
    initial begin
        st_t e;
        int  got;
        forever begin
            @(negedge clk);
            #2;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("gnt_a", int'(gnt_a), e.ga);
                chk("gnt_b", int'(gnt_b), e.gb);
                chk("sel", int'(sel), e.sl);
                chk("beat_cnt", int'(beat_cnt), e.cnt);
                chk("y_valid", int'(y_valid), e.vld);
                chk("y", int'(y), e.yv);
            end
            if (y_valid && ready) begin
                got = ((gnt_b ? 2 : 1) << W) | int'(y);
                if (xfer_q.size() == 0) chk("unexpected_xfer", got, -1);
                else                    chk("xfer", got, xfer_q.pop_front());
            end
        end
    end

    initial begin
        bit ra, rb;
        int pr;
        model_reset();
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);

        // Tie from reset, forced release at MAX_BURST, direct hand-over
        repeat (14) cycle(1, 1, 0, 1, 0, 1, W'($urandom), W'($urandom));
        repeat (3) cycle(1, 0, 0, 0, 0, 1, 8'h11, 8'h22);

        // Single requester, last on third beat, then drop
        for (int i = 0; i < 6; i++)
            cycle(1, 1, (m_owner == 1 && m_cnt == 2), 0, 0, 1, 8'h3C, 8'h55);
        repeat (2) cycle(1, 0, 0, 0, 0, 1, 8'h3C, 8'h55);

        // Backpressure mid-burst
        repeat (2) cycle(1, 1, 0, 0, 0, 1, 8'hA1, 8'h00);
        repeat (5) cycle(1, 1, 0, 0, 0, 0, 8'hA2, 8'h00);
        repeat (3) cycle(1, 1, 0, 0, 0, 1, 8'hA3, 8'h00);
        repeat (2) cycle(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);

        // Abandon: B drops before last with A waiting, then again with A idle
        repeat (3) cycle(1, 0, 0, 1, 0, 1, 8'h00, 8'hB1);
        cycle(1, 1, 0, 0, 0, 1, 8'hC1, 8'hB2);
        repeat (2) cycle(1, 1, 0, 0, 0, 1, 8'hC2, 8'h00);
        repeat (4) cycle(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        repeat (2) cycle(1, 0, 0, 1, 0, 1, 8'h00, 8'hB3);
        repeat (2) cycle(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);

        // Asynchronous reset with A granted and beat_cnt at 2
        repeat (3) cycle(1, 1, 0, 0, 0, 1, 8'h77, 8'h00);
        cycle(1, 1, 0, 0, 0, 0, 8'h77, 8'h00);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt_a", int'(gnt_a), 0);
        chk("async_rst_y_valid", int'(y_valid), 0);
        chk("async_rst_sel", int'(sel), 0);
        chk("async_rst_beat_cnt", int'(beat_cnt), 0);
        model_reset();
        repeat (2) cycle(0, 1, 0, 1, 0, 1, 8'h01, 8'h02);

        // Randomized traffic with varying ready and last density
        ra = 0; rb = 0;
        for (int ph = 0; ph < 4; ph++) begin
            pr = 1 + ph;
            for (int i = 0; i < 600; i++) begin
                ra = ra ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                rb = rb ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                cycle(1, ra, $urandom_range(0, pr) == 0, rb, $urandom_range(0, pr) == 0,
                      $urandom_range(0, 3) < pr, W'($urandom), W'($urandom));
            end
        end
        repeat (3) cycle(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);

        @(negedge clk);
        #4;
        chk("xfer_queue_drained", xfer_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
